// File: rtl/dffr_pipe_bank.sv
// dffr_pipe_bank: WIDTH x DEPTH resettable pipeline register bank with enable, scan chain and fill-valid flag
//   CLK  clock, all state updates on posedge
//   R    synchronous active-high reset, loads RST_VAL and clears valid
//   EN   advance the data pipe by one stage
//   SE   scan mode, shifts the whole bank one bit (overrides EN)
//   SI   scan serial input into stage 0 bit 0
//   D    parallel data into stage 0
//   Q    last stage, QN its inverse, SO its MSB (scan out)
//   VLD  last stage holds data captured from D
module dffr_pipe_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             EN,
    input  logic             SE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             SO,
    output logic             VLD
);
    localparam int N = WIDTH * DEPTH;
    // stage s occupies bits [s*WIDTH +: WIDTH]; bit order is also the scan chain order
    logic [N-1:0]     st;
    logic [DEPTH-1:0] v;
    logic [N-1:0]     st_adv;
    logic [N-1:0]     st_scan;
    logic [DEPTH-1:0] v_adv;
    assign st_adv  = (st << WIDTH) | N'(D);
    assign st_scan = (st << 1) | N'(SI);
    assign v_adv   = (v << 1) | DEPTH'(1);
    // ternary chain keeps X on R/SE/EN propagating to state instead of silently picking a branch
    always_ff @(posedge CLK) begin
        st <= R ? {DEPTH{RST_VAL}} : SE ? st_scan : EN ? st_adv : st;
        v  <= R ? '0 : SE ? v : EN ? v_adv : v;
    end
    assign Q   = st[N-1 -: WIDTH];
    assign QN  = ~Q;
    assign SO  = st[N-1];
    assign VLD = v[DEPTH-1];
endmodule

// File: tb/tb_dffr_pipe_bank.sv
// tb_dffr_pipe_bank: directed self-checking bench for dffr_pipe_bank (WIDTH=4, DEPTH=3, RST_VAL=4'hA)
module tb_dffr_pipe_bank;
    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic       EN = 1'b0;
    logic       SE = 1'b0;
    logic       SI = 1'b0;
    logic [3:0] D = 4'h0;
    logic [3:0] Q;
    logic [3:0] QN;
    logic       SO;
    logic       VLD;
    int total = 0;
    int bad = 0;

    dffr_pipe_bank #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'hA)) dut (
        .CLK(CLK), .R(R), .EN(EN), .SE(SE), .SI(SI), .D(D),
        .Q(Q), .QN(QN), .SO(SO), .VLD(VLD)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic r, input logic en, input logic se, input logic si, input logic [3:0] d);
        R = r; EN = en; SE = se; SI = si; D = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        // reset wins over EN/D
        drive(1, 1, 0, 0, 4'h5); tick();
        chk("rst_q", Q, 4'hA);
        chk("rst_qn", QN, 4'h5);
        chk("rst_so", {3'b0, SO}, 4'h1);
        chk("rst_vld", {3'b0, VLD}, 4'h0);
        // fill
        drive(0, 1, 0, 0, 4'h1); tick();
        drive(0, 1, 0, 0, 4'h2); tick();
        chk("fill2_q", Q, 4'hA);
        chk("fill2_vld", {3'b0, VLD}, 4'h0);
        drive(0, 1, 0, 0, 4'h3); tick();
        chk("fill3_q", Q, 4'h1);
        chk("fill3_vld", {3'b0, VLD}, 4'h1);
        drive(0, 1, 0, 0, 4'h4); tick();
        chk("fill4_q", Q, 4'h2);
        chk("fill4_qn", QN, 4'hD);
        // stall
        drive(0, 1, 0, 0, 4'h7); tick();
        drive(0, 1, 0, 0, 4'h8); tick();
        drive(0, 1, 0, 0, 4'h9); tick();
        chk("stall_pre_q", Q, 4'h7);
        drive(0, 0, 0, 0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_q", Q, 4'h7);
        end
        chk("stall_vld", {3'b0, VLD}, 4'h1);
        drive(0, 1, 0, 0, 4'hF); tick();
        chk("reen_q", Q, 4'h8);
        // scan all ones after reset: SO shows residue 1,0 then the first shifted-in 1
        drive(1, 0, 0, 0, 4'h0); tick();
        drive(0, 0, 1, 1, 4'h0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 10) chk("scan_so10", {3'b0, SO}, 4'h1);
            if (i == 11) chk("scan_so11", {3'b0, SO}, 4'h0);
            if (i == 12) chk("scan_so12", {3'b0, SO}, 4'h1);
        end
        chk("scan_q", Q, 4'hF);
        chk("scan_vld", {3'b0, VLD}, 4'h0);
        // priority: SE with EN shifts one bit only, D ignored, VLD held
        drive(1, 0, 0, 0, 4'h0); tick();
        drive(0, 1, 0, 0, 4'h3); tick();
        drive(0, 1, 0, 0, 4'h5); tick();
        drive(0, 1, 0, 0, 4'h6); tick();
        chk("prio_pre_q", Q, 4'h3);
        drive(0, 1, 1, 0, 4'h5); tick();
        chk("prio_q", Q, 4'h6);
        chk("prio_so", {3'b0, SO}, 4'h0);
        chk("prio_vld", {3'b0, VLD}, 4'h1);
        drive(0, 1, 0, 0, 4'h0); tick();
        chk("prio_adv1_q", Q, 4'hA);
        tick();
        chk("prio_adv2_q", Q, 4'hC);
        // reset beats scan
        drive(1, 0, 1, 1, 4'h0); tick();
        chk("rst_se_q", Q, 4'hA);
        chk("rst_se_vld", {3'b0, VLD}, 4'h0);
        // mid-fill reset discards partial contents
        drive(0, 1, 0, 0, 4'h7); tick();
        drive(0, 1, 0, 0, 4'h8); tick();
        drive(1, 1, 0, 0, 4'h9); tick();
        chk("mid_rst_q", Q, 4'hA);
        chk("mid_rst_vld", {3'b0, VLD}, 4'h0);
        drive(0, 1, 0, 0, 4'h1); tick();
        drive(0, 1, 0, 0, 4'h2); tick();
        chk("mid_fill2_vld", {3'b0, VLD}, 4'h0);
        chk("mid_fill2_q", Q, 4'hA);
        drive(0, 1, 0, 0, 4'h3); tick();
        chk("mid_fill3_vld", {3'b0, VLD}, 4'h1);
        chk("mid_fill3_q", Q, 4'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
